// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_arb_pkg
//   Shared types, default constants and the round-robin helper for the
//   FIFO write-side arbiter (and any read-side scheduler that reuses rr_pick).
//   Contents:
//     arb_state_e      - arbiter FSM states (IDLE, BURST)
//     DEF_DATA_WIDTH   - default word width (matches async_fifo wr_data)
//     DEF_NUM_REQ      - default number of requesters
//     DEF_MAX_BURST    - default maximum words per grant
//     MAX_REQ          - largest requester count next_rr supports
//     next_rr()        - round-robin winner search starting after 'last'
package fifo_arb_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 16;
    localparam int unsigned DEF_NUM_REQ    = 4;
    localparam int unsigned DEF_MAX_BURST  = 8;
    localparam int unsigned MAX_REQ        = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    // Returns the first set bit of req_vec searching last+1, last+2, ...
    // modulo num_req. With no bit set, 'last' is returned unchanged.
    // The loop runs over the fixed MAX_REQ range so it unrolls statically.
    function automatic logic [2:0] next_rr(
        input logic [MAX_REQ-1:0] req_vec,
        input logic [2:0]         last,
        input int unsigned        num_req
    );
        logic [2:0]  win;
        logic        found;
        int unsigned idx;
        win   = last;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAX_REQ; k++) begin
            if (k <= num_req) begin
                idx = (32'(last) + k) % num_req;
                if (!found && req_vec[3'(idx)]) begin
                    win   = 3'(idx);
                    found = 1'b1;
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if
//   Bundles the producer handshake and the async_fifo write port.
//   Signals:
//     req_valid    - per-requester word valid
//     req_data     - packed words, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//     req_ready    - per-requester accept
//     fifo_full    - async_fifo full flag
//     fifo_wr_en   - async_fifo write enable
//     fifo_wr_data - async_fifo write data
//   Modports:
//     slave  - the arbiter's view
//     master - the producers / FIFO view (drives valid, data and full)
interface fifo_wr_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 16
) ();

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH-1:0]         fifo_wr_data;

    modport slave (
        input  req_valid,
        input  req_data,
        input  fifo_full,
        output req_ready,
        output fifo_wr_en,
        output fifo_wr_data
    );

    modport master (
        output req_valid,
        output req_data,
        output fifo_full,
        input  req_ready,
        input  fifo_wr_en,
        input  fifo_wr_data
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin priority picker.
//   Ports:
//     req_vec    in  NUM_REQ          request bits
//     last_grant in  $clog2(NUM_REQ)  previous winner (search starts after it)
//     winner     out $clog2(NUM_REQ)  selected requester (last_grant if none)
//     any        out 1                at least one request bit set
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]         req_vec,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant,
    output logic [$clog2(NUM_REQ)-1:0] winner,
    output logic                       any
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [MAX_REQ-1:0] req_ext;
    logic [2:0]         last_ext;
    logic [2:0]         win_ext;

    always_comb begin
        req_ext                = '0;
        req_ext[NUM_REQ-1:0]   = req_vec;
        last_ext               = '0;
        last_ext[IDX_W-1:0]    = last_grant;
        win_ext                = next_rr(req_ext, last_ext, NUM_REQ);
        winner                 = win_ext[IDX_W-1:0];
        any                    = |req_vec;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter sharing the async_fifo write port between NUM_REQ
//   producers in the wr_clk domain. One producer is granted at a time for a
//   burst of up to MAX_BURST words; fifo_full stalls the burst without ending
//   it. Throughput and stall counters saturate at all-ones.
//   Ports:
//     wr_clk        in   write-domain clock
//     wr_rst        in   synchronous active-high reset
//     arb_en        in   1 = new grants allowed
//     wr_bus        if   producer handshake + FIFO write port (slave view)
//     grant_id      out  current or last grantee
//     busy          out  1 while bursting
//     words_written out  accepted words (saturating)
//     full_stalls   out  burst cycles spent with fifo_full=1 (saturating)
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned MAX_BURST  = DEF_MAX_BURST,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                       wr_clk,
    input  logic                       wr_rst,
    input  logic                       arb_en,
    fifo_wr_arbiter_if.slave           wr_bus,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic [CNT_WIDTH-1:0]       words_written,
    output logic [CNT_WIDTH-1:0]       full_stalls
);

    localparam int unsigned IDX_W  = $clog2(NUM_REQ);
    localparam int unsigned BEAT_W = $clog2(MAX_BURST + 1);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   grant_id_q, grant_id_d;
    logic [IDX_W-1:0]   last_grant_q, last_grant_d;
    logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [CNT_WIDTH-1:0] words_q, words_d;
    logic [CNT_WIDTH-1:0] stalls_q, stalls_d;

    logic [IDX_W-1:0]   rr_winner;
    logic               rr_any;
    logic               grant_valid;
    logic               xfer;
    logic [NUM_REQ-1:0] ready;
    logic [BEAT_W-1:0]  beat_inc;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req_vec    (wr_bus.req_valid),
        .last_grant (last_grant_q),
        .winner     (rr_winner),
        .any        (rr_any)
    );

    // Transfer qualification; reset masks it combinationally so nothing is
    // accepted or written in a reset cycle even mid-burst.
    always_comb begin
        grant_valid = wr_bus.req_valid[grant_id_q];
        xfer        = (state_q == BURST) && grant_valid && !wr_bus.fifo_full && !wr_rst;
        ready       = '0;
        if (xfer) begin
            ready[grant_id_q] = 1'b1;
        end
    end

    assign wr_bus.req_ready    = ready;
    assign wr_bus.fifo_wr_en   = xfer;
    assign wr_bus.fifo_wr_data = wr_bus.req_data[32'(grant_id_q) * DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        words_d      = words_q;
        stalls_d     = stalls_q;
        beat_inc     = beat_cnt_q + BEAT_W'(1);

        unique case (state_q)
            IDLE: begin
                if (arb_en && rr_any) begin
                    grant_id_d   = rr_winner;
                    last_grant_d = rr_winner;
                    beat_cnt_d   = '0;
                    state_d      = BURST;
                end
            end
            BURST: begin
                // Priority: transfer, then full (stall), then dropped valid.
                if (xfer) begin
                    beat_cnt_d = beat_inc;
                    if (beat_inc == BEAT_W'(MAX_BURST)) begin
                        state_d = IDLE;
                    end
                end else if (wr_bus.fifo_full) begin
                    if (stalls_q != '1) begin
                        stalls_d = stalls_q + CNT_WIDTH'(1);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (xfer && (words_q != '1)) begin
            words_d = words_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            state_q      <= IDLE;
            grant_id_q   <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            beat_cnt_q   <= '0;
            words_q      <= '0;
            stalls_q     <= '0;
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            words_q      <= words_d;
            stalls_q     <= stalls_d;
        end
    end

    assign grant_id      = grant_id_q;
    assign busy          = (state_q == BURST);
    assign words_written = words_q;
    assign full_stalls   = stalls_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
//   Directed scenarios plus a randomized soak for fifo_wr_arbiter, checked
//   every cycle against a transaction-level reference model.
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 16;
    localparam int MB = 8;
    localparam int CW = 32;

    logic          wr_clk = 1'b0;
    logic          wr_rst = 1'b1;
    logic          arb_en = 1'b1;
    logic [1:0]    grant_id;
    logic          busy;
    logic [CW-1:0] words_written;
    logic [CW-1:0] full_stalls;

    fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    fifo_wr_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB),
        .CNT_WIDTH  (CW)
    ) dut (
        .wr_clk        (wr_clk),
        .wr_rst        (wr_rst),
        .arb_en        (arb_en),
        .wr_bus        (bus),
        .grant_id      (grant_id),
        .busy          (busy),
        .words_written (words_written),
        .full_stalls   (full_stalls)
    );

    always #5 wr_clk = ~wr_clk;

    // ---------------- reference model ----------------
    typedef struct {
        int gid;
        int data;
        int cyc;
    } xfer_t;

    int     m_busy = 0;
    int     m_gid = 0;
    int     m_last = NR - 1;
    int     m_beats = 0;
    longint m_words = 0;
    longint m_stalls = 0;
    int     cyc = 0;
    int     sent [NR];
    xfer_t  xlog [$];

    function automatic int rr_next(logic [NR-1:0] v, int last);
        for (int k = 1; k <= NR; k++) begin
            int idx;
            idx = (last + k) % NR;
            if (v[idx]) return idx;
        end
        return last;
    endfunction

    function automatic int word_of(logic [NR*DW-1:0] d, int i);
        logic [DW-1:0] w;
        w = d[i*DW +: DW];
        return int'(w);
    endfunction

    initial begin
        for (int i = 0; i < NR; i++) sent[i] = 0;
    end

    always @(posedge wr_clk) begin
        logic [NR-1:0]    v;
        logic [NR*DW-1:0] d;
        v = bus.req_valid;
        d = bus.req_data;
        cyc++;
        if (wr_rst) begin
            m_busy = 0; m_gid = 0; m_last = NR - 1; m_beats = 0;
            m_words = 0; m_stalls = 0;
        end else if (m_busy == 0) begin
            if (arb_en && (v != '0)) begin
                m_gid   = rr_next(v, m_last);
                m_last  = m_gid;
                m_beats = 0;
                m_busy  = 1;
            end
        end else if (bus.fifo_full) begin
            if (m_stalls < 64'hFFFF_FFFF) m_stalls++;
        end else if (v[m_gid]) begin
            xlog.push_back('{m_gid, word_of(d, m_gid), cyc});
            sent[m_gid]++;
            if (m_words < 64'hFFFF_FFFF) m_words++;
            m_beats++;
            if (m_beats == MB) m_busy = 0;
        end else begin
            m_busy = 0;
        end
    end

    // ---------------- checking ----------------
    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    task automatic check(string name, longint act, longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_cycle();
        int               exp_x;
        logic [NR-1:0]    exp_ready;
        exp_x     = (m_busy != 0) && bus.req_valid[m_gid] && !bus.fifo_full && !wr_rst;
        exp_ready = '0;
        if (exp_x != 0) exp_ready[m_gid] = 1'b1;
        check("fifo_wr_en",    longint'(bus.fifo_wr_en), longint'(exp_x));
        check("req_ready",     longint'(bus.req_ready), longint'(exp_ready));
        check("fifo_wr_data",  longint'(bus.fifo_wr_data), longint'(word_of(bus.req_data, m_gid)));
        check("grant_id",      longint'(grant_id), longint'(m_gid));
        check("busy",          longint'(busy), longint'(m_busy));
        check("words_written", longint'(words_written), m_words);
        check("full_stalls",   longint'(full_stalls), m_stalls);
    endtask

    // ---------------- stimulus ----------------
    bit rand_mode = 1'b0;
    int quota [NR];
    int base  [NR];
    int start [NR];

    task automatic apply();
        logic [NR-1:0]    v;
        logic [NR*DW-1:0] d;
        for (int i = 0; i < NR; i++) begin
            if (rand_mode) begin
                v[i]          = ($urandom_range(0, 9) < 7);
                d[i*DW +: DW] = DW'($urandom);
            end else begin
                v[i]          = ((sent[i] - start[i]) < quota[i]);
                d[i*DW +: DW] = DW'(base[i] + sent[i] - start[i]);
            end
        end
        bus.req_valid = v;
        bus.req_data  = d;
    endtask

    task automatic tick();
        apply();
        @(negedge wr_clk);
        if (chk_en) compare_cycle();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic set_quota(int i, int q, int b);
        quota[i] = q;
        base[i]  = b;
        start[i] = sent[i];
    endtask

    task automatic clear_quotas();
        for (int i = 0; i < NR; i++) set_quota(i, 0, 0);
    endtask

    task automatic do_reset();
        clear_quotas();
        bus.fifo_full = 1'b0;
        arb_en = 1'b1;
        wr_rst = 1'b1;
        tick();
        tick();
        wr_rst = 1'b0;
    endtask

    function automatic int log_gid(int idx);
        if (idx < xlog.size()) return xlog[idx].gid;
        return -1;
    endfunction

    task automatic wait_sent(int i, int n, string name);
        int budget;
        budget = 60;
        while (((sent[i] - start[i]) < n) && (budget > 0)) begin
            tick();
            budget--;
        end
        check(name, longint'((sent[i] - start[i]) >= n), 1);
    endtask

    initial begin
        int t0;
        int ls;
        bus.fifo_full = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        clear_quotas();
        wr_rst = 1'b1;
        tick();
        chk_en = 1'b1;

        // T1: single requester, 5 words then valid drops
        do_reset();
        set_quota(0, 5, 100);
        t0 = cyc;
        ls = xlog.size();
        check("t1_reset_words", longint'(words_written), 0);
        check("t1_reset_grant", longint'(grant_id), 0);
        repeat (10) tick();
        check("t1_count", xlog.size() - ls, 5);
        for (int k = 0; k < 5 && (ls + k) < xlog.size(); k++) begin
            check("t1_data", xlog[ls + k].data, 100 + k);
            check("t1_cyc",  xlog[ls + k].cyc - t0, 2 + k);
        end
        check("t1_words_written", longint'(words_written), 5);
        check("t1_grant_id", longint'(grant_id), 0);
        check("t1_busy", longint'(busy), 0);

        // T2: all requesters streaming, fair rotation with one idle cycle
        do_reset();
        for (int i = 0; i < NR; i++) set_quota(i, 1000, i * 4096);
        t0 = cyc;
        ls = xlog.size();
        repeat (36) tick();
        check("t2_words_written", longint'(words_written), 32);
        for (int k = 0; k < 32; k++) begin
            check("t2_gid", log_gid(ls + k), k / 8);
            if ((ls + k) < xlog.size())
                check("t2_cyc", xlog[ls + k].cyc - t0, 2 + 9 * (k / 8) + (k % 8));
        end
        repeat (3) tick();
        check("t2_wrap_gid", log_gid(ls + 32), 0);

        // T3: full for 3 cycles after beat 4 of requester 2
        do_reset();
        set_quota(2, 8, 16'h2000);
        ls = xlog.size();
        wait_sent(2, 4, "t3_wait_beat4");
        bus.fifo_full = 1'b1;
        repeat (3) tick();
        bus.fifo_full = 1'b0;
        repeat (10) tick();
        check("t3_full_stalls", longint'(full_stalls), 3);
        check("t3_count", xlog.size() - ls, 8);
        for (int k = 0; k < 8 && (ls + k) < xlog.size(); k++) begin
            check("t3_gid", xlog[ls + k].gid, 2);
            check("t3_data", xlog[ls + k].data, 16'h2000 + k);
        end
        if ((ls + 4) < xlog.size())
            check("t3_gap", xlog[ls + 4].cyc - xlog[ls + 3].cyc, 4);

        // T4: last_grant=1, valid=1001 -> 3 then 0
        do_reset();
        set_quota(1, 1, 16'h1000);
        repeat (4) tick();
        check("t4_first_gid", longint'(grant_id), 1);
        set_quota(0, 8, 16'h0100);
        set_quota(3, 8, 16'h3000);
        ls = xlog.size();
        repeat (25) tick();
        check("t4_gid_a", log_gid(ls), 3);
        check("t4_gid_b", log_gid(ls + 8), 0);
        check("t4_count", xlog.size() - ls, 16);

        // T5: arb_en dropped during requester 1's burst
        do_reset();
        set_quota(1, 20, 16'h1100);
        set_quota(2, 20, 16'h2200);
        ls = xlog.size();
        wait_sent(1, 2, "t5_wait_beat2");
        arb_en = 1'b0;
        repeat (15) tick();
        check("t5_words_written", longint'(words_written), 8);
        check("t5_busy", longint'(busy), 0);
        check("t5_grant_id", longint'(grant_id), 1);
        arb_en = 1'b1;
        repeat (3) tick();
        check("t5_next_gid", log_gid(ls + 8), 2);

        // T6: reset at beat 3
        do_reset();
        for (int i = 0; i < NR; i++) set_quota(i, 20, i * 256);
        wait_sent(0, 3, "t6_wait_beat3");
        wr_rst = 1'b1;
        apply();
        #1;
        check("t6_rst_wr_en", longint'(bus.fifo_wr_en), 0);
        check("t6_rst_ready", longint'(bus.req_ready), 0);
        tick();
        wr_rst = 1'b0;
        check("t6_words", longint'(words_written), 0);
        check("t6_stalls", longint'(full_stalls), 0);
        check("t6_busy", longint'(busy), 0);
        ls = xlog.size();
        repeat (4) tick();
        check("t6_next_gid", log_gid(ls), 0);

        // Randomized soak
        do_reset();
        rand_mode = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            bus.fifo_full = ($urandom_range(0, 3) == 0);
            arb_en        = ($urandom_range(0, 9) != 0);
            wr_rst        = ($urandom_range(0, 99) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
